// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a word on a valid/ready handshake and
// shifts it out one bit per enabled clock with first/last framing and zero-gap reload.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] p_in,
    input  logic             load,
    output logic             p_ready,
    input  logic             shift_en,
    output logic             s_out,
    output logic             s_valid,
    output logic             s_first,
    output logic             s_last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             s_out_d, s_valid_d, s_first_d, s_last_d;
    logic             at_last;
    logic             accept;

    // The shift register always holds the bits still to be sent, aligned so the
    // next one sits at the end selected by LSB_FIRST.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    assign at_last = (state == SHIFT) && (cnt == LAST);
    assign p_ready = (state == IDLE) || (at_last && shift_en);
    assign accept  = load && p_ready;

    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        cnt_d     = cnt;
        s_out_d   = s_out;
        s_valid_d = s_valid;
        s_first_d = s_first;
        s_last_d  = s_last;

        if (accept) begin
            state_d   = SHIFT;
            shreg_d   = advance(p_in);
            cnt_d     = '0;
            s_out_d   = head(p_in);
            s_valid_d = 1'b1;
            s_first_d = 1'b1;
            s_last_d  = 1'b0;
        end else if ((state == SHIFT) && shift_en) begin
            if (cnt == LAST) begin
                // Final bit consumed with no new word waiting: line goes quiet.
                state_d   = IDLE;
                shreg_d   = '0;
                cnt_d     = '0;
                s_out_d   = 1'b0;
                s_valid_d = 1'b0;
                s_first_d = 1'b0;
                s_last_d  = 1'b0;
            end else begin
                shreg_d   = advance(shreg);
                cnt_d     = cnt + CW'(1);
                s_out_d   = head(shreg);
                s_first_d = 1'b0;
                s_last_d  = (cnt_d == LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            s_out   <= 1'b0;
            s_valid <= 1'b0;
            s_first <= 1'b0;
            s_last  <= 1'b0;
        end else begin
            state   <= state_d;
            shreg   <= shreg_d;
            cnt     <= cnt_d;
            s_out   <= s_out_d;
            s_valid <= s_valid_d;
            s_first <= s_first_d;
            s_last  <= s_last_d;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: a 4-bit LSB-first instance under random stalls and
// back-to-back words, plus an 8-bit MSB-first instance, both checked against a bit queue model.
module tb_piso_tx;

    localparam int W  = 4;
    localparam int W2 = 8;

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } slot_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  p_in;
    logic          load;
    logic          shift_en;
    logic          p_ready, s_out, s_valid, s_first, s_last;
    logic [W2-1:0] p_in2;
    logic          load2;
    logic          shift_en2;
    logic          p_ready2, s_out2, s_valid2, s_first2, s_last2;

    slot_t exp_q[$];
    slot_t exp_q2[$];
    logic  se_script[$];
    bit    rand_se;
    int    acc_count  = 0;
    int    acc_count2 = 0;
    int    errors     = 0;
    int    checks     = 0;

    piso_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .p_in(p_in), .load(load), .p_ready(p_ready),
        .shift_en(shift_en), .s_out(s_out), .s_valid(s_valid),
        .s_first(s_first), .s_last(s_last)
    );

    piso_tx #(.WIDTH(W2), .LSB_FIRST(1'b0)) dut2 (
        .clk(clk), .rst(rst), .p_in(p_in2), .load(load2), .p_ready(p_ready2),
        .shift_en(shift_en2), .s_out(s_out2), .s_valid(s_valid2),
        .s_first(s_first2), .s_last(s_last2)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic report_timeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out at %0t", name, $time);
    endtask

    // Model: the queue holds every bit slot still owed on the line, so its size is
    // the number of remaining bits and its head is what the line must show now.
    always @(negedge clk) begin
        logic rdy;
        if (!rst) begin
            exp_q.delete();
            check_output("rst_s_valid", s_valid, 1'b0);
            check_output("rst_s_out", s_out, 1'b0);
            check_output("rst_p_ready", p_ready, 1'b1);
        end else begin
            rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && shift_en);
            check_output("p_ready", p_ready, rdy);
            check_output("s_valid", s_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check_output("s_out", s_out, exp_q[0].b);
                check_output("s_first", s_first, exp_q[0].f);
                check_output("s_last", s_last, exp_q[0].l);
                if (shift_en) void'(exp_q.pop_front());
            end else begin
                check_output("idle_s_out", s_out, 1'b0);
                check_output("idle_s_first", s_first, 1'b0);
                check_output("idle_s_last", s_last, 1'b0);
            end
            if (load && rdy) begin
                for (int i = 0; i < W; i++) begin
                    slot_t e;
                    e.b = p_in[i];
                    e.f = (i == 0);
                    e.l = (i == W - 1);
                    exp_q.push_back(e);
                end
                acc_count++;
            end
        end
    end

    always @(negedge clk) begin
        logic rdy;
        if (!rst) begin
            exp_q2.delete();
            check_output("rst2_s_valid", s_valid2, 1'b0);
        end else begin
            rdy = (exp_q2.size() == 0) || (exp_q2.size() == 1 && shift_en2);
            check_output("p_ready2", p_ready2, rdy);
            check_output("s_valid2", s_valid2, exp_q2.size() != 0);
            if (exp_q2.size() != 0) begin
                check_output("s_out2", s_out2, exp_q2[0].b);
                check_output("s_first2", s_first2, exp_q2[0].f);
                check_output("s_last2", s_last2, exp_q2[0].l);
                if (shift_en2) void'(exp_q2.pop_front());
            end
            if (load2 && rdy) begin
                for (int i = 0; i < W2; i++) begin
                    slot_t e;
                    e.b = p_in2[W2 - 1 - i];
                    e.f = (i == 0);
                    e.l = (i == W2 - 1);
                    exp_q2.push_back(e);
                end
                acc_count2++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (se_script.size() != 0) shift_en = se_script.pop_front();
        else if (rand_se)          shift_en = ($urandom_range(0, 3) != 0);
        else                       shift_en = 1'b1;
    endtask

    // Holds load and the word until the model sees the handshake complete.
    task automatic apply_stimulus(input logic [W-1:0] w);
        int start;
        int n;
        start = acc_count;
        p_in  = w;
        load  = 1'b1;
        n     = 0;
        do begin
            tick();
            n++;
        end while (acc_count == start && n < 200);
        if (acc_count == start) report_timeout("accept");
        load = 1'b0;
        p_in = W'($urandom);
    endtask

    task automatic apply_stimulus2(input logic [W2-1:0] w);
        int start;
        int n;
        start = acc_count2;
        p_in2 = w;
        load2 = 1'b1;
        n     = 0;
        do begin
            tick();
            n++;
        end while (acc_count2 == start && n < 200);
        if (acc_count2 == start) report_timeout("accept2");
        load2 = 1'b0;
        p_in2 = W2'($urandom);
    endtask

    task automatic drain();
        int n;
        load  = 1'b0;
        load2 = 1'b0;
        n     = 0;
        while ((exp_q.size() != 0 || exp_q2.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || exp_q2.size() != 0) report_timeout("drain");
        tick();
    endtask

    initial begin
        rst       = 1'b0;
        p_in      = '0;
        load      = 1'b0;
        shift_en  = 1'b1;
        p_in2     = '0;
        load2     = 1'b0;
        shift_en2 = 1'b1;
        rand_se   = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();

        // Single word, then back-to-back pair with no gap.
        apply_stimulus(4'b1001);
        drain();
        apply_stimulus(4'b1001);
        apply_stimulus(4'b0110);
        drain();

        // Stall after the second bit.
        se_script = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        apply_stimulus(4'b1100);
        drain();

        // Load while busy must wait for the last-bit edge.
        apply_stimulus(4'b0001);
        tick();
        apply_stimulus(4'b1111);
        drain();

        // Asynchronous reset between edges while bit 3 is on the line.
        apply_stimulus(4'b0100);
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        check_output("async_s_out", s_out, 1'b0);
        check_output("async_s_valid", s_valid, 1'b0);
        check_output("async_s_first", s_first, 1'b0);
        check_output("async_s_last", s_last, 1'b0);
        check_output("async_p_ready", p_ready, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        repeat (3) tick();

        // MSB-first byte instance.
        apply_stimulus2(8'hA5);
        apply_stimulus2(8'h3C);
        for (int k = 0; k < 6; k++) apply_stimulus2(W2'($urandom));
        drain();

        // Random words, random stalls, random idle gaps.
        rand_se = 1'b1;
        for (int k = 0; k < 80; k++) begin
            apply_stimulus(W'($urandom));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
